// File: rtl/btb_update_queue_if.sv
// Bundle between the retire stage, fetch arbitration and the BTB write port.
//   slave  : the update queue (consumes retire updates, drives the BTB write port)
//   master : the surrounding core / testbench
// Signals: rt0_*/rt1_* retire slots (slot 0 older), fetch_read_en fetch-read
// priority, write_en/PC_in/data_in BTB write port, count/empty occupancy,
// drop registered discard pulse.
interface btb_update_queue_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) ();
   logic                       rt0_valid;
   logic [XLEN-1:0]            rt0_pc;
   logic [XLEN-1:0]            rt0_target;
   logic                       rt1_valid;
   logic [XLEN-1:0]            rt1_pc;
   logic [XLEN-1:0]            rt1_target;
   logic                       fetch_read_en;
   logic                       write_en;
   logic [XLEN-1:0]            PC_in;
   logic [XLEN-1:0]            data_in;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       empty;
   logic                       drop;

   modport slave (
      input  rt0_valid, rt0_pc, rt0_target,
      input  rt1_valid, rt1_pc, rt1_target,
      input  fetch_read_en,
      output write_en, PC_in, data_in, count, empty, drop
   );

   modport master (
      output rt0_valid, rt0_pc, rt0_target,
      output rt1_valid, rt1_pc, rt1_target,
      output fetch_read_en,
      input  write_en, PC_in, data_in, count, empty, drop
   );
endinterface

// File: rtl/btb_update_queue.sv
// BTB write-side front end. Buffers resolved taken branches from both retire
// slots in an in-order circular queue, coalesces repeated PCs in place, and
// drains one entry per cycle into the BTB write port whenever fetch is not
// reading the BTB.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   bus    - btb_update_queue_if.slave (retire slots, fetch_read_en, BTB
//            write port, count/empty/drop status)
module btb_update_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                clock,
   input  logic                reset,
   btb_update_queue_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [XLEN-1:0]  pc_q  [DEPTH];
   logic [XLEN-1:0]  tgt_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [CW-1:0]    count_q;
   logic             drop_q;

   logic             empty;
   logic             pop;
   logic             merged;
   logic             req0;
   logic             req1;
   logic [DEPTH-1:0] match0;
   logic [DEPTH-1:0] match1;
   logic             new0;
   logic             new1;
   logic [CW:0]      free;
   logic             acc0;
   logic             acc1;
   logic [PW-1:0]    wr0;
   logic [PW-1:0]    wr1;
   logic [1:0]       n_acc;

   assign empty = (count_q == '0);
   assign pop   = !empty && !bus.fetch_read_en;

   // Same PC in both slots collapses to one update carrying the younger target.
   assign merged = bus.rt0_valid && bus.rt1_valid && (bus.rt0_pc == bus.rt1_pc);
   assign req0   = bus.rt0_valid && !merged;
   assign req1   = bus.rt1_valid;

   // The entry leaving this cycle cannot absorb an update: its old target is
   // already on the write port, so a fresh entry must carry the new one.
   // If a duplicate exists behind a non-popping head, both copies take the
   // new target, which keeps the final BTB contents correct.
   always_comb begin
      match0 = '0;
      match1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && !(pop && (head_q == PW'(i)))) begin
            match0[i] = req0 && (pc_q[i] == bus.rt0_pc);
            match1[i] = req1 && (pc_q[i] == bus.rt1_pc);
         end
      end
   end

   assign new0  = req0 && (match0 == '0);
   assign new1  = req1 && (match1 == '0);

   // A pop in the same cycle frees its slot for an incoming entry.
   assign free  = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
   assign acc0  = new0 && (free != '0);
   assign acc1  = new1 && (free > (CW+1)'(acc0));
   assign wr0   = tail_q;
   assign wr1   = tail_q + PW'(acc0);
   assign n_acc = {1'b0, acc0} + {1'b0, acc1};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]  <= '0;
            tgt_q[i] <= '0;
         end
         vld_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            // A push into the slot being popped (full queue) must win.
            if (acc0 && (wr0 == PW'(i))) begin
               pc_q[i]  <= bus.rt0_pc;
               tgt_q[i] <= bus.rt0_target;
               vld_q[i] <= 1'b1;
            end else if (acc1 && (wr1 == PW'(i))) begin
               pc_q[i]  <= bus.rt1_pc;
               tgt_q[i] <= bus.rt1_target;
               vld_q[i] <= 1'b1;
            end else begin
               if (pop && (head_q == PW'(i)))
                  vld_q[i] <= 1'b0;
               if (match0[i])
                  tgt_q[i] <= bus.rt0_target;
               if (match1[i])
                  tgt_q[i] <= bus.rt1_target;
            end
         end
         head_q  <= head_q + PW'(pop);
         tail_q  <= tail_q + PW'(n_acc);
         count_q <= count_q + CW'(n_acc) - CW'(pop);
         drop_q  <= (new0 && !acc0) || (new1 && !acc1);
      end
   end

   assign bus.write_en = pop;
   assign bus.PC_in    = empty ? '0 : pc_q[head_q];
   assign bus.data_in  = empty ? '0 : tgt_q[head_q];
   assign bus.count    = count_q;
   assign bus.empty    = empty;
   assign bus.drop     = drop_q;
endmodule

// File: tb/tb_btb_update_queue.sv
module tb_btb_update_queue;
   logic clock;
   logic reset;
   int   checks;
   int   errors;

   btb_update_queue_if #(.DEPTH(4), .XLEN(32)) bus ();

   btb_update_queue #(.DEPTH(4), .XLEN(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.rt0_valid  = 1'b0;
      bus.rt0_pc     = '0;
      bus.rt0_target = '0;
      bus.rt1_valid  = 1'b0;
      bus.rt1_pc     = '0;
      bus.rt1_target = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.fetch_read_en = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (bus.write_en !== 1'b0) begin errors++; $display("FAIL rst_we: got %0d expected 0", bus.write_en); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0d expected 1", bus.empty); end
      checks++; if (bus.PC_in !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", bus.PC_in); end
      checks++; if (bus.data_in !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", bus.data_in); end
      checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", bus.drop); end

      // Queue two entries, then reset asynchronously mid-cycle while draining.
      bus.fetch_read_en = 1'b1;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0000_0100; bus.rt0_target = 32'h0000_0200;
      bus.rt1_valid = 1'b1; bus.rt1_pc = 32'h0000_0300; bus.rt1_target = 32'h0000_0400;
      tick();
      idle_inputs();
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d expected 2", bus.count); end
      bus.fetch_read_en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d expected 0", bus.count); end
      checks++; if (bus.write_en !== 1'b0) begin errors++; $display("FAIL rst_async_we: got %0d expected 0", bus.write_en); end
      checks++; if (bus.PC_in !== 32'h0) begin errors++; $display("FAIL rst_async_pc: got %h expected 0", bus.PC_in); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_async_empty: got %0d expected 1", bus.empty); end
      tick();
      reset = 1'b0;
      tick();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_after_empty: got %0d expected 1", bus.empty); end
   endtask

   task automatic test_single();
      bus.fetch_read_en = 1'b0;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0806_002C; bus.rt0_target = 32'h1122_1320;
      #1;
      checks++; if (bus.write_en !== 1'b0) begin errors++; $display("FAIL single_nobypass: got %0d expected 0", bus.write_en); end
      tick();
      idle_inputs();
      checks++; if (bus.write_en !== 1'b1) begin errors++; $display("FAIL single_we: got %0d expected 1", bus.write_en); end
      checks++; if (bus.PC_in !== 32'h0806_002C) begin errors++; $display("FAIL single_pc: got %h expected 0806002c", bus.PC_in); end
      checks++; if (bus.data_in !== 32'h1122_1320) begin errors++; $display("FAIL single_data: got %h expected 11221320", bus.data_in); end
      tick();
      checks++; if (bus.write_en !== 1'b0) begin errors++; $display("FAIL single_we_after: got %0d expected 0", bus.write_en); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %0d expected 1", bus.empty); end
   endtask

   task automatic test_fetch_priority();
      bus.fetch_read_en = 1'b1;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0806_002C; bus.rt0_target = 32'h1122_1320;
      bus.rt1_valid = 1'b1; bus.rt1_pc = 32'h1027_00E8; bus.rt1_target = 32'h0313_0575;
      tick();
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL fetch_count cyc%0d: got %0d expected 2", c, bus.count); end
         checks++; if (bus.write_en !== 1'b0) begin errors++; $display("FAIL fetch_we cyc%0d: got %0d expected 0", c, bus.write_en); end
         tick();
      end
      bus.fetch_read_en = 1'b0;
      #1;
      checks++; if (bus.write_en !== 1'b1) begin errors++; $display("FAIL fetch_w1_we: got %0d expected 1", bus.write_en); end
      checks++; if (bus.PC_in !== 32'h0806_002C) begin errors++; $display("FAIL fetch_w1_pc: got %h expected 0806002c", bus.PC_in); end
      checks++; if (bus.data_in !== 32'h1122_1320) begin errors++; $display("FAIL fetch_w1_data: got %h expected 11221320", bus.data_in); end
      tick();
      checks++; if (bus.write_en !== 1'b1) begin errors++; $display("FAIL fetch_w2_we: got %0d expected 1", bus.write_en); end
      checks++; if (bus.PC_in !== 32'h1027_00E8) begin errors++; $display("FAIL fetch_w2_pc: got %h expected 102700e8", bus.PC_in); end
      checks++; if (bus.data_in !== 32'h0313_0575) begin errors++; $display("FAIL fetch_w2_data: got %h expected 03130575", bus.data_in); end
      tick();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fetch_empty: got %0d expected 1", bus.empty); end
   endtask

   task automatic test_coalesce();
      bus.fetch_read_en = 1'b1;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h1027_00E8; bus.rt0_target = 32'h0313_0575;
      tick();
      bus.rt0_target = 32'hAC2D_7569;
      tick();
      idle_inputs();
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL coal_count: got %0d expected 1", bus.count); end
      bus.fetch_read_en = 1'b0;
      #1;
      checks++; if (bus.data_in !== 32'hAC2D_7569) begin errors++; $display("FAIL coal_data: got %h expected ac2d7569", bus.data_in); end
      checks++; if (bus.write_en !== 1'b1) begin errors++; $display("FAIL coal_we: got %0d expected 1", bus.write_en); end
      tick();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL coal_single: got empty=%0d expected 1", bus.empty); end

      // Same PC in both slots in one cycle: younger target wins.
      bus.fetch_read_en = 1'b1;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0750_002C; bus.rt0_target = 32'h0000_0001;
      bus.rt1_valid = 1'b1; bus.rt1_pc = 32'h0750_002C; bus.rt1_target = 32'h0000_0002;
      tick();
      idle_inputs();
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL merge_count: got %0d expected 1", bus.count); end
      bus.fetch_read_en = 1'b0;
      #1;
      checks++; if (bus.PC_in !== 32'h0750_002C) begin errors++; $display("FAIL merge_pc: got %h expected 0750002c", bus.PC_in); end
      checks++; if (bus.data_in !== 32'h0000_0002) begin errors++; $display("FAIL merge_data: got %h expected 00000002", bus.data_in); end
      tick();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL merge_empty: got %0d expected 1", bus.empty); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_pc [4];
      logic [31:0] exp_tg [4];
      exp_pc[0] = 32'h0000_2000; exp_tg[0] = 32'h0000_B000;
      exp_pc[1] = 32'h0000_3000; exp_tg[1] = 32'h0000_C000;
      exp_pc[2] = 32'h0000_4000; exp_tg[2] = 32'h0000_D000;
      exp_pc[3] = 32'h0000_6000; exp_tg[3] = 32'h0000_F000;
      bus.fetch_read_en = 1'b1;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0000_1000; bus.rt0_target = 32'h0000_A000;
      bus.rt1_valid = 1'b1; bus.rt1_pc = 32'h0000_2000; bus.rt1_target = 32'h0000_B000;
      tick();
      bus.rt1_valid = 1'b0;
      bus.rt0_pc = 32'h0000_3000; bus.rt0_target = 32'h0000_C000;
      tick();
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL ovf_count3: got %0d expected 3", bus.count); end
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0000_4000; bus.rt0_target = 32'h0000_D000;
      bus.rt1_valid = 1'b1; bus.rt1_pc = 32'h0000_5000; bus.rt1_target = 32'h0000_E000;
      tick();
      idle_inputs();
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_count4: got %0d expected 4", bus.count); end
      checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL ovf_drop: got %0d expected 1", bus.drop); end
      tick();
      checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL ovf_drop_pulse: got %0d expected 0", bus.drop); end

      // Full queue with a pop: one slot frees, slot 0 fits, slot 1 dropped.
      bus.fetch_read_en = 1'b0;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0000_6000; bus.rt0_target = 32'h0000_F000;
      bus.rt1_valid = 1'b1; bus.rt1_pc = 32'h0000_7000; bus.rt1_target = 32'h0000_0700;
      #1;
      checks++; if (bus.PC_in !== 32'h0000_1000) begin errors++; $display("FAIL ovf_pop_pc: got %h expected 00001000", bus.PC_in); end
      tick();
      idle_inputs();
      bus.fetch_read_en = 1'b1;
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_pop_count: got %0d expected 4", bus.count); end
      checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL ovf_pop_drop: got %0d expected 1", bus.drop); end
      tick();
      bus.fetch_read_en = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.PC_in !== exp_pc[k] || bus.data_in !== exp_tg[k])
            begin errors++; $display("FAIL ovf_order%0d: got %h/%h expected %h/%h", k, bus.PC_in, bus.data_in, exp_pc[k], exp_tg[k]); end
         tick();
      end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %0d expected 1", bus.empty); end
   endtask

   task automatic test_head_pop_race();
      bus.fetch_read_en = 1'b1;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0806_002C; bus.rt0_target = 32'h1122_1320;
      bus.rt1_valid = 1'b1; bus.rt1_pc = 32'h1027_00E8; bus.rt1_target = 32'h0313_0575;
      tick();
      idle_inputs();
      bus.fetch_read_en = 1'b0;
      bus.rt0_valid = 1'b1; bus.rt0_pc = 32'h0806_002C; bus.rt0_target = 32'h2000_0000;
      #1;
      checks++; if (bus.write_en !== 1'b1 || bus.data_in !== 32'h1122_1320)
         begin errors++; $display("FAIL race_cur: got we=%0d data=%h expected 1/11221320", bus.write_en, bus.data_in); end
      tick();
      idle_inputs();
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL race_count: got %0d expected 2", bus.count); end
      checks++; if (bus.PC_in !== 32'h1027_00E8) begin errors++; $display("FAIL race_w2_pc: got %h expected 102700e8", bus.PC_in); end
      tick();
      checks++; if (bus.PC_in !== 32'h0806_002C || bus.data_in !== 32'h2000_0000)
         begin errors++; $display("FAIL race_w3: got %h/%h expected 0806002c/20000000", bus.PC_in, bus.data_in); end
      tick();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL race_empty: got %0d expected 1", bus.empty); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.fetch_read_en = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_fetch_priority();
      test_coalesce();
      test_overflow();
      test_head_pop_race();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
